// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data load/store.
// Define MEMARB_RR_EN for round-robin conflict resolution; default is data-priority with fetch starvation guard.
module mem_arbiter #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_req_i,
  input  logic [ADDRWIDTH-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_rvalid_o,
  output logic [DATAWIDTH-1:0] if_rdata_o,
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  logic [ADDRWIDTH-1:0] dm_addr_i,
  input  logic [DATAWIDTH-1:0] dm_wdata_i,
  output logic                 dm_gnt_o,
  output logic                 dm_rvalid_o,
  output logic [DATAWIDTH-1:0] dm_rdata_o,
  output logic                 mem_re_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

  owner_e owner_q, owner_d;
  logic   if_win;

`ifdef MEMARB_RR_EN
  logic last_dm_q, last_dm_d;

  // The requester that was not granted last wins a conflict.
  assign if_win = last_dm_q;

  always_comb begin
    last_dm_d = last_dm_q;
    if (if_gnt_o)      last_dm_d = 1'b0;
    else if (dm_gnt_o) last_dm_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) last_dm_q <= 1'b0;
    else        last_dm_q <= last_dm_d;
  end
`else
  logic [3:0] starve_q, starve_d;

  assign if_win = (starve_q == 4'(STARVE_LIMIT));

  // Count conflicts lost by fetch; any fetch grant clears the count.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt_o)
      starve_d = '0;
    else if (if_req_i && dm_gnt_o && (starve_q != 4'(STARVE_LIMIT)))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    if_gnt_o    = rst_i & if_req_i & (~dm_req_i | if_win);
    dm_gnt_o    = rst_i & dm_req_i & (~if_req_i | ~if_win);
    mem_re_o    = if_gnt_o | (dm_gnt_o & ~dm_we_i);
    mem_we_o    = dm_gnt_o & dm_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
    end else if (dm_gnt_o) begin
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt_o)                 owner_d = OWN_IF;
    else if (dm_gnt_o && !dm_we_i) owner_d = OWN_DM;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  assign if_rvalid_o = (owner_q == OWN_IF);
  assign dm_rvalid_o = (owner_q == OWN_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

endmodule
